// File: rtl/sensor_dma_arbiter_pkg.sv
// Shared types and widths for the sensor DMA arbiter: arbiter state enum and
// the memory-interface / counter widths used by every file of the block.
package sensor_dma_arbiter_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int TS_W   = 24;
  localparam int PIN_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/sensor_dma_arbiter_if.sv
// Data-memory bus seen by the arbiter: processor request side in, RAM port out.
// Handshake: cpu_req marks a processor access this cycle; when cpu_stall is high
// the processor must hold that same access and retry on the next cycle.
interface sensor_dma_arbiter_if;
  import sensor_dma_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_stall;
  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;

  // master: processor/RAM environment; slave: the arbiter itself
  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_data,
    input  cpu_stall, ram_wEn, ram_addr, ram_dataIn
  );

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_data,
    output cpu_stall, ram_wEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/sensor_tick_gen.sv
// Sensor pin synchronizer plus the sample-interval timer that produces the
// one-cycle sampling tick.
module sensor_tick_gen
  import sensor_dma_arbiter_pkg::*;
#(
  parameter int PERIOD = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [PIN_W-1:0] i_pins,
  output logic [PIN_W-1:0] o_sync,
  output logic             o_tick
);
  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);

  logic [PIN_W-1:0] r_meta;
  logic [PIN_W-1:0] r_sync;
  logic [TW-1:0]    r_timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_timer <= '0;
    end else begin
      r_meta <= i_pins;
      r_sync <= r_meta;
      if (!i_enable || (r_timer == TIMER_LAST)) r_timer <= '0;
      else                                      r_timer <= r_timer + TW'(1);
    end
  end

  assign o_sync = r_sync;
  assign o_tick = i_enable && (r_timer == TIMER_LAST);
endmodule

// File: rtl/sensor_dma_arbiter.sv
// Shares the data-memory port between the processor (priority) and a periodic
// sensor-sampling DMA writing a RAM ring buffer. Build option SENSOR_TIMESTAMP_EN
// prefixes each stored sample with a 24-bit cycle timestamp taken at its tick.
module sensor_dma_arbiter
  import sensor_dma_arbiter_pkg::*;
#(
  parameter int                PERIOD    = 1000,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hF00,
  parameter int                MAX_WAIT  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [PIN_W-1:0] in_pins,
  sensor_dma_arbiter_if.slave bus,
  output logic [CNT_W-1:0] head_ptr,
  output logic [CNT_W-1:0] overrun_count,
  output arb_state_e       o_dbg_state
);
  localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_e        r_state, w_state_n;
  logic [CNT_W-1:0]  r_wait, w_wait_n;
  logic [CNT_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_ovr;
  logic [PIN_W-1:0]  r_sample;
  logic [PIN_W-1:0]  w_sync;
  logic              w_tick;
  logic              w_grant;
  logic              w_stall;
  logic              w_accept;
  logic [DATA_W-1:0] w_word;

  sensor_tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
    .clock    (clock),
    .reset    (reset),
    .i_enable (enable),
    .i_pins   (in_pins),
    .o_sync   (w_sync),
    .o_tick   (w_tick)
  );

  assign w_accept = w_tick && (r_state == IDLE);

`ifdef SENSOR_TIMESTAMP_EN
  logic [TS_W-1:0] r_cycle;
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle <= '0;
      r_ts    <= '0;
    end else begin
      r_cycle <= r_cycle + TS_W'(1);
      if (w_accept) r_ts <= r_cycle;
    end
  end

  assign w_word = {r_ts, r_sample};
`else
  assign w_word = {{(DATA_W - PIN_W){1'b0}}, r_sample};
`endif

  always_comb begin
    w_state_n = r_state;
    w_wait_n  = r_wait;
    w_grant   = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_n = PENDING;
          w_wait_n  = '0;
        end
      end
      PENDING: begin
        if (!bus.cpu_req) begin
          w_grant   = 1'b1;
          w_state_n = IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_state_n = FORCE;
        end else begin
          w_wait_n = r_wait + CNT_W'(1);
        end
      end
      FORCE: begin
        w_grant   = 1'b1;
        w_stall   = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_head   <= '0;
      r_ovr    <= '0;
      r_sample <= '0;
    end else begin
      r_state <= w_state_n;
      r_wait  <= w_wait_n;
      if (w_accept) r_sample <= w_sync;
      if (w_grant) r_head <= (r_head == HEAD_LAST) ? '0 : r_head + CNT_W'(1);
      // A tick arriving while a sample is still outstanding is lost
      if (w_tick && (r_state != IDLE) && (r_ovr != '1)) r_ovr <= r_ovr + CNT_W'(1);
    end
  end

  assign bus.cpu_stall  = w_stall;
  assign bus.ram_wEn    = reset ? 1'b0 : (w_grant ? 1'b1 : bus.cpu_wren);
  assign bus.ram_addr   = w_grant ? BASE_ADDR + {{(ADDR_W - CNT_W){1'b0}}, r_head} : bus.cpu_addr;
  assign bus.ram_dataIn = w_grant ? w_word : bus.cpu_data;

  assign head_ptr      = r_head;
  assign overrun_count = r_ovr;
  assign o_dbg_state   = r_state;
endmodule
